// File: rtl/cpu_reset_sequencer.sv
// CPU reset sequencer: qualifies PLL lock, stretches reset, records last cause and count.
// Optional watchdog enabled with `define RST_SEQ_WDT_EN.
module cpu_reset_sequencer #(
   parameter int unsigned LOCK_HOLD_CYCLES = 1024,
   parameter int unsigned RST_HOLD_CYCLES  = 16,
   parameter int unsigned WDT_CYCLES       = 1048576
) (
   input  logic       clk_i,
   input  logic       rst_n,
   input  logic       pll_locked_i,
   input  logic       btn_rst_i,
   input  logic       wdt_kick_i,
   output logic       cpu_rst_o,
   output logic [1:0] state_o,
   output logic [1:0] rst_cause_o,
   output logic [7:0] rst_count_o
);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'b00,
      ST_STABLE    = 2'b01,
      ST_HOLD      = 2'b10,
      ST_RUN       = 2'b11
   } state_e;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_BTN  = 2'b01;
   localparam logic [1:0] CAUSE_LOCK = 2'b10;
   localparam logic [1:0] CAUSE_WDT  = 2'b11;

   localparam int unsigned CNT_MAX = (LOCK_HOLD_CYCLES > RST_HOLD_CYCLES) ?
                                     LOCK_HOLD_CYCLES : RST_HOLD_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 32'd1) ? $clog2(CNT_MAX) : 32'd1;
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_HOLD_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 32'd1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic [1:0]       cause_q, cause_d;
   logic [7:0]       count_q, count_d;
   logic             wdt_expire_s;

`ifdef RST_SEQ_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 32'd1);

   logic [WDT_W-1:0] wdt_q, wdt_d;

   // A kick landing in the expiry cycle wins over the timeout.
   assign wdt_expire_s = (state_q == ST_RUN) && (wdt_q == WDT_LAST) && !wdt_kick_i;

   // Watchdog count: advances only while running, otherwise held at zero.
   always_comb begin
      wdt_d = '0;
      if ((state_q == ST_RUN) && !wdt_kick_i) begin
         wdt_d = wdt_q + WDT_W'(1);
      end else begin
         wdt_d = '0;
      end
   end

   // Watchdog register.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`else
   logic unused_wdt_s;
   assign unused_wdt_s = wdt_kick_i ^ (WDT_CYCLES == 32'd0);
   assign wdt_expire_s = 1'b0;
`endif

   // Sequencer next-state, hold counter and RUN-exit bookkeeping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      count_d = count_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            cnt_d = '0;
            if (pll_locked_i) begin
               state_d = ST_STABLE;
            end else begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            if (!pll_locked_i) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (!pll_locked_i) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (btn_rst_i) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            cnt_d = '0;
            if (!pll_locked_i || btn_rst_i || wdt_expire_s) begin
               count_d = (count_q == 8'd255) ? count_q : count_q + 8'd1;
               if (!pll_locked_i) begin
                  state_d = ST_WAIT_LOCK;
                  cause_d = CAUSE_LOCK;
               end else if (btn_rst_i) begin
                  state_d = ST_HOLD;
                  cause_d = CAUSE_BTN;
               end else begin
                  state_d = ST_HOLD;
                  cause_d = CAUSE_WDT;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
      cpu_rst_d = (state_d != ST_RUN);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_WAIT_LOCK;
         cnt_q     <= '0;
         cpu_rst_q <= 1'b1;
         cause_q   <= CAUSE_POR;
         count_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cpu_rst_q <= cpu_rst_d;
         cause_q   <= cause_d;
         count_q   <= count_d;
      end
   end

   assign cpu_rst_o   = cpu_rst_q;
   assign state_o     = state_q;
   assign rst_cause_o = cause_q;
   assign rst_count_o = count_q;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Directed bench for cpu_reset_sequencer (LOCK_HOLD=8, RST_HOLD=4, WDT=32).
// Watchdog expectations follow `define RST_SEQ_WDT_EN.
module tb_cpu_reset_sequencer;

   logic       clk;
   logic       rst_n;
   logic       pll_locked;
   logic       btn_rst;
   logic       wdt_kick;
   logic       cpu_rst;
   logic [1:0] state;
   logic [1:0] rst_cause;
   logic [7:0] rst_count;

   int n_checks;
   int n_fail;

   cpu_reset_sequencer #(
      .LOCK_HOLD_CYCLES(8),
      .RST_HOLD_CYCLES (4),
      .WDT_CYCLES      (32)
   ) dut (
      .clk_i       (clk),
      .rst_n       (rst_n),
      .pll_locked_i(pll_locked),
      .btn_rst_i   (btn_rst),
      .wdt_kick_i  (wdt_kick),
      .cpu_rst_o   (cpu_rst),
      .state_o     (state),
      .rst_cause_o (rst_cause),
      .rst_count_o (rst_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held over two edges, released 1 time unit after an edge.
   task automatic apply_reset();
      rst_n    = 1'b0;
      btn_rst  = 1'b0;
      wdt_kick = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic go_run();
      pll_locked = 1'b1;
      apply_reset();
      repeat (13) tick();
   endtask

   task automatic test_reset();
      pll_locked = 1'b0;
      apply_reset();
      n_checks++;
      if ({state, cpu_rst, rst_cause, rst_count} !== {2'b00, 1'b1, 2'b00, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_values: got st=%b rst=%b cause=%b cnt=%0d required 00 1 00 0",
                  state, cpu_rst, rst_cause, rst_count);
      end
      repeat (5) tick();
      n_checks++;
      if ({state, cpu_rst} !== {2'b00, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_no_lock: got st=%b rst=%b required 00 1", state, cpu_rst);
      end
   endtask

   task automatic test_power_on();
      logic [1:0] exp_st;
      logic       exp_rst;
      pll_locked = 1'b1;
      apply_reset();
      for (int e = 1; e <= 13; e++) begin
         tick();
         exp_st  = (e <= 8) ? 2'b01 : ((e <= 12) ? 2'b10 : 2'b11);
         exp_rst = (e < 13);
         n_checks++;
         if ({state, cpu_rst} !== {exp_st, exp_rst}) begin
            n_fail++;
            $display("FAIL power_on edge %0d: got st=%b rst=%b required st=%b rst=%b",
                     e, state, cpu_rst, exp_st, exp_rst);
         end
      end
      n_checks++;
      if ({rst_cause, rst_count} !== {2'b00, 8'd0}) begin
         n_fail++;
         $display("FAIL power_on_cause: got cause=%b cnt=%0d required 00 0", rst_cause, rst_count);
      end
   endtask

   task automatic test_lock_glitch();
      logic [1:0] exp_st;
      pll_locked = 1'b1;
      apply_reset();
      repeat (6) tick();
      pll_locked = 1'b0;
      tick();
      n_checks++;
      if ({state, cpu_rst} !== {2'b00, 1'b1}) begin
         n_fail++;
         $display("FAIL glitch_drop: got st=%b rst=%b required 00 1", state, cpu_rst);
      end
      pll_locked = 1'b1;
      for (int j = 0; j <= 12; j++) begin
         tick();
         exp_st = (j < 8) ? 2'b01 : ((j < 12) ? 2'b10 : 2'b11);
         n_checks++;
         if ({state, cpu_rst} !== {exp_st, (j < 12)}) begin
            n_fail++;
            $display("FAIL glitch_recount step %0d: got st=%b rst=%b required st=%b rst=%b",
                     j, state, cpu_rst, exp_st, (j < 12));
         end
      end
      n_checks++;
      if ({rst_cause, rst_count} !== {2'b00, 8'd0}) begin
         n_fail++;
         $display("FAIL glitch_count: got cause=%b cnt=%0d required 00 0", rst_cause, rst_count);
      end
   endtask

   task automatic test_button();
      go_run();
      btn_rst = 1'b1;
      tick();
      btn_rst = 1'b0;
      n_checks++;
      if ({state, cpu_rst, rst_cause, rst_count} !== {2'b10, 1'b1, 2'b01, 8'd1}) begin
         n_fail++;
         $display("FAIL button_enter: got st=%b rst=%b cause=%b cnt=%0d required 10 1 01 1",
                  state, cpu_rst, rst_cause, rst_count);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++;
         if (cpu_rst !== (i < 4)) begin
            n_fail++;
            $display("FAIL button_hold cycle %0d: got rst=%b required %b", i, cpu_rst, (i < 4));
         end
      end
      // Second button press two cycles into HOLD restarts the hold.
      btn_rst = 1'b1;
      tick();
      btn_rst = 1'b0;
      tick();
      tick();
      btn_rst = 1'b1;
      tick();
      btn_rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++;
         if ({state, cpu_rst} !== ((i < 4) ? {2'b10, 1'b1} : {2'b11, 1'b0})) begin
            n_fail++;
            $display("FAIL button_rehold cycle %0d: got st=%b rst=%b", i, state, cpu_rst);
         end
      end
      n_checks++;
      if ({rst_cause, rst_count} !== {2'b01, 8'd2}) begin
         n_fail++;
         $display("FAIL button_count: got cause=%b cnt=%0d required 01 2", rst_cause, rst_count);
      end
   endtask

   task automatic test_simultaneous();
      go_run();
      btn_rst    = 1'b1;
      pll_locked = 1'b0;
      tick();
      btn_rst = 1'b0;
      n_checks++;
      if ({state, cpu_rst, rst_cause, rst_count} !== {2'b00, 1'b1, 2'b10, 8'd1}) begin
         n_fail++;
         $display("FAIL simultaneous: got st=%b rst=%b cause=%b cnt=%0d required 00 1 10 1",
                  state, cpu_rst, rst_cause, rst_count);
      end
      tick();
      n_checks++;
      if ({state, rst_count} !== {2'b00, 8'd1}) begin
         n_fail++;
         $display("FAIL simultaneous_stay: got st=%b cnt=%0d required 00 1", state, rst_count);
      end
      pll_locked = 1'b1;
   endtask

   task automatic test_saturation();
      logic [7:0] exp_cnt;
      go_run();
      for (int i = 1; i <= 300; i++) begin
         btn_rst = 1'b1;
         tick();
         btn_rst = 1'b0;
         repeat (4) tick();
         exp_cnt = (i > 255) ? 8'd255 : 8'(i);
         n_checks++;
         if ({state, rst_count} !== {2'b11, exp_cnt}) begin
            n_fail++;
            $display("FAIL saturation iter %0d: got st=%b cnt=%0d required 11 %0d",
                     i, state, rst_count, exp_cnt);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({state, cpu_rst, rst_cause, rst_count} !== {2'b00, 1'b1, 2'b00, 8'd0}) begin
         n_fail++;
         $display("FAIL async_reset: got st=%b rst=%b cause=%b cnt=%0d required 00 1 00 0",
                  state, cpu_rst, rst_cause, rst_count);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_watchdog();
`ifdef RST_SEQ_WDT_EN
      go_run();
      for (int i = 1; i <= 32; i++) begin
         tick();
         n_checks++;
         if (state !== ((i < 32) ? 2'b11 : 2'b10)) begin
            n_fail++;
            $display("FAIL wdt_expire tick %0d: got st=%b", i, state);
         end
      end
      n_checks++;
      if ({cpu_rst, rst_cause, rst_count} !== {1'b1, 2'b11, 8'd1}) begin
         n_fail++;
         $display("FAIL wdt_cause: got rst=%b cause=%b cnt=%0d required 1 11 1",
                  cpu_rst, rst_cause, rst_count);
      end
      go_run();
      for (int i = 1; i <= 1000; i++) begin
         wdt_kick = (i % 20 == 0);
         tick();
         n_checks++;
         if (state !== 2'b11) begin
            n_fail++;
            $display("FAIL wdt_kicked tick %0d: got st=%b required 11", i, state);
         end
      end
      wdt_kick = 1'b0;
      // Kick exactly in the expiry cycle keeps the core running.
      go_run();
      repeat (31) tick();
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      n_checks++;
      if ({state, cpu_rst, rst_count} !== {2'b11, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL wdt_kick_wins: got st=%b rst=%b cnt=%0d required 11 0 0",
                  state, cpu_rst, rst_count);
      end
`else
      go_run();
      for (int i = 1; i <= 100; i++) begin
         tick();
         n_checks++;
         if ({state, rst_cause} !== {2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL wdt_off tick %0d: got st=%b cause=%b required 11 00", i, state, rst_cause);
         end
      end
`endif
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      btn_rst    = 1'b0;
      wdt_kick   = 1'b0;
      test_reset();
      test_power_on();
      test_lock_glitch();
      test_button();
      test_simultaneous();
      test_saturation();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
